// File: rtl/alu_pkg.sv
// Shared definitions for the ALU output stage.
//   ALU_W / FLAG_W : data and status-flag widths
//   FLG_*          : bit positions inside the {sign,zero,carry,parity,overflow} flag vector
//   fifo_state_t   : occupancy encoding of the 2-entry skid FIFO
package alu_pkg;
    localparam int ALU_W      = 16;
    localparam int FLAG_W     = 5;

    localparam int FLG_SIGN   = 4;
    localparam int FLG_ZERO   = 3;
    localparam int FLG_CARRY  = 2;
    localparam int FLG_PARITY = 1;
    localparam int FLG_OVF    = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fifo_state_t;
endpackage

// File: rtl/alu_skid_fifo2.sv
// Generic 2-entry skid FIFO with valid/ready handshake on both sides.
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : write handshake; in_ready is a registered decode of the occupancy
//   in_data         : write payload
//   out_valid/ready : read handshake; out_valid is registered
//   out_data        : oldest stored entry
// The head entry is always held in head_q, so out_data is a plain register
// output and stays stable while the consumer stalls.
module alu_skid_fifo2
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W + FLAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    fifo_state_t      state;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             push;
    logic             pop;

    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign out_data = head_q;

    // in_ready / out_valid are updated together with the state so that both
    // are pure flops with no path from out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            head_q    <= '0;
            tail_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_q    <= in_data;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        // Head leaves and the new beat takes its place.
                        head_q <= in_data;
                    end else if (push) begin
                        tail_q   <= in_data;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (pop) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_q   <= tail_q;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/alu_result_capture.sv
// Registered capture stage behind the combinational 16-bit ALU.
// Buffers {z, flags} in a 2-entry skid FIFO, keeps sticky status flags and a
// saturating count of overflow beats.
// Optional build macro ALU_PARITY_CHECK_EN: checks the parity input against
// ~^z on every accepted beat and raises a sticky parity_err on mismatch;
// without it parity_err is constant 0.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : ALU side handshake
//   z, sign..overflow    : ALU result and status flags
//   out_valid/out_ready  : consumer handshake
//   out_data, out_flags  : head entry ({sign,zero,carry,parity,overflow})
//   sticky_flags         : OR of flags of all accepted beats since clear
//   sticky_clr           : synchronous clear of sticky_flags/ovf_count/parity_err
//   ovf_count            : saturating count of accepted overflow beats
//   parity_err           : sticky parity mismatch
module alu_result_capture
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  z,
    input  logic              sign,
    input  logic              zero,
    input  logic              carry,
    input  logic              parity,
    input  logic              overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [FLAG_W-1:0] out_flags,
    output logic [FLAG_W-1:0] sticky_flags,
    input  logic              sticky_clr,
    output logic [CNT_W-1:0]  ovf_count,
    output logic              parity_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [FLAG_W-1:0]       flags;
    logic [WIDTH+FLAG_W-1:0] fifo_out;
    logic                    accept;
    logic                    ovf_beat;

    assign flags    = {sign, zero, carry, parity, overflow};
    assign accept   = in_valid & in_ready;
    assign ovf_beat = accept & flags[FLG_OVF];

    alu_skid_fifo2 #(
        .WIDTH (WIDTH + FLAG_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({z, flags}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_out)
    );

    assign out_data  = fifo_out[WIDTH+FLAG_W-1:FLAG_W];
    assign out_flags = fifo_out[FLAG_W-1:0];

    // Clear wins first, then the beat accepted in the same cycle is applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
            ovf_count    <= '0;
        end else if (sticky_clr) begin
            sticky_flags <= accept ? flags : '0;
            ovf_count    <= {{(CNT_W-1){1'b0}}, ovf_beat};
        end else begin
            if (accept)
                sticky_flags <= sticky_flags | flags;
            if (ovf_beat && ovf_count != CNT_MAX)
                ovf_count <= ovf_count + 1'b1;
        end
    end

`ifdef ALU_PARITY_CHECK_EN
    logic par_mismatch;

    // parity=1 means z holds an even number of ones, i.e. ~^z.
    assign par_mismatch = accept & ((~^z) != parity);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_err <= 1'b0;
        else if (sticky_clr)
            parity_err <= par_mismatch;
        else if (par_mismatch)
            parity_err <= 1'b1;
    end
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_capture.sv
module tb_alu_result_capture;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] z;
    logic        sign, zero, carry, parity, overflow;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  out_flags;
    logic [4:0]  sticky_flags;
    logic        sticky_clr;
    logic [7:0]  ovf_count;
    logic        parity_err;

`ifdef ALU_PARITY_CHECK_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    alu_result_capture #(.WIDTH(16), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .z            (z),
        .sign         (sign),
        .zero         (zero),
        .carry        (carry),
        .parity       (parity),
        .overflow     (overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .ovf_count    (ovf_count),
        .parity_err   (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  flags;
    } sb_t;

    typedef struct {
        logic [15:0] z;
        logic [4:0]  flags;
        logic        clr;
        logic [4:0]  sticky;
        logic [7:0]  cnt;
        logic        perr;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[8];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One beat driven just after a rising edge; captured at the next edge.
    task automatic beat(input logic [15:0] zz, input logic [4:0] ff, input logic clr);
        @(posedge clk); #1;
        in_valid   = 1'b1;
        z          = zz;
        {sign, zero, carry, parity, overflow} = ff;
        sticky_clr = clr;
        if (in_ready) sb.push_back('{zz, ff});
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid   = 1'b0;
        sticky_clr = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_timeout"}, 32'(out_valid), 32'd0);
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard: every head popped by the consumer must match the oldest push.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual=%0h required=none", out_data);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_data", 32'(out_data), 32'(e.data));
                chk("sb_flags", 32'(out_flags), 32'(e.flags));
            end
        end
    end

    initial begin
        logic [4:0] ff;
        tbl[0] = '{16'h0FFF, 5'b00111, 1'b0, 5'b00111, 8'd1, 1'b0};
        tbl[1] = '{16'h0000, 5'b01110, 1'b0, 5'b01111, 8'd1, 1'b0};
        tbl[2] = '{16'hFFFF, 5'b10010, 1'b0, 5'b11111, 8'd1, 1'b0};
        tbl[3] = '{16'hFFFF, 5'b10010, 1'b1, 5'b10010, 8'd0, 1'b0};
        tbl[4] = '{16'h1234, 5'b00001, 1'b0, 5'b10011, 8'd1, 1'b0};
        tbl[5] = '{16'h0001, 5'b00010, 1'b0, 5'b10011, 8'd1, PAR_EN};
        tbl[6] = '{16'h8000, 5'b10001, 1'b0, 5'b10011, 8'd2, PAR_EN};
        tbl[7] = '{16'h0003, 5'b00010, 1'b1, 5'b00010, 8'd0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
        z = '0; {sign, zero, carry, parity, overflow} = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_sticky", 32'(sticky_flags), 32'd0);
        chk("idle_cnt", 32'(ovf_count), 32'd0);
        chk("idle_perr", 32'(parity_err), 32'd0);

        // Table: one beat per row with a free-running consumer.
        for (int i = 0; i < 8; i++) begin
            beat(tbl[i].z, tbl[i].flags, tbl[i].clr);
            idle();
            @(negedge clk);
            chk("tbl_latency_valid", 32'(out_valid), 32'd1);
            chk("tbl_latency_data", 32'(out_data), 32'(tbl[i].z));
            chk("tbl_sticky", 32'(sticky_flags), 32'(tbl[i].sticky));
            chk("tbl_cnt", 32'(ovf_count), 32'(tbl[i].cnt));
            chk("tbl_perr", 32'(parity_err), 32'(tbl[i].perr));
        end
        drain("tbl");

        // Back-pressure: fill both entries, third beat must be dropped.
        @(posedge clk); #1 out_ready = 1'b0;
        beat(16'h0000, 5'b01110, 1'b0);
        beat(16'hFFFF, 5'b10010, 1'b0);
        beat(16'h5555, 5'b00001, 1'b0);
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_head_data", 32'(out_data), 32'h0000);
            chk("bp_head_flags", 32'(out_flags), 32'(5'b01110));
        end
        chk("bp_sticky", 32'(sticky_flags), 32'(5'b11110));
        chk("bp_cnt", 32'(ovf_count), 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        drain("bp");

        // Counter saturation.
        for (int i = 0; i < 254; i++) begin
            ff = {3'b000, ~^(16'(i)), 1'b1};
            beat(16'(i), ff, 1'b0);
        end
        idle();
        @(negedge clk);
        chk("sat_cnt_254", 32'(ovf_count), 32'd254);
        for (int i = 254; i < 300; i++) begin
            ff = {3'b000, ~^(16'(i)), 1'b1};
            beat(16'(i), ff, 1'b0);
        end
        idle();
        @(negedge clk);
        chk("sat_cnt_max", 32'(ovf_count), 32'hFF);
        chk("sat_sticky", 32'(sticky_flags), 32'(5'b11111));
        drain("sat");

        // Clear without a beat.
        @(posedge clk); #1 sticky_clr = 1'b1;
        @(posedge clk); #1 sticky_clr = 1'b0;
        @(negedge clk);
        chk("clr_sticky", 32'(sticky_flags), 32'd0);
        chk("clr_cnt", 32'(ovf_count), 32'd0);

        // Asynchronous reset while full.
        @(posedge clk); #1 out_ready = 1'b0;
        beat(16'hAAAA, 5'b10011, 1'b0);
        beat(16'h0F0F, 5'b00011, 1'b0);
        idle();
        @(negedge clk);
        chk("two_in_ready", 32'(in_ready), 32'd0);
        chk("two_cnt", 32'(ovf_count), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_sticky", 32'(sticky_flags), 32'd0);
        chk("arst_cnt", 32'(ovf_count), 32'd0);
        sb.delete();
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
